// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module  : y86_pkg
// Brief   : Shared Y86-64 encodings for the fetch stage: instruction codes,
//           status codes, the "no register" specifier, fetch FSM states and
//           an instruction-length helper.
// Revision: 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes (upper nibble of the first instruction byte)
  localparam logic [3:0] INOP    = 4'h0;
  localparam logic [3:0] IHALT   = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status encodings
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Register specifier meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    F_OP    = 3'd0,
    F_REG   = 3'd1,
    F_CONST = 3'd2,
    OUT     = 3'd3,
    WAIT_PC = 3'd4,
    HALTED  = 3'd5
  } fetch_state_e;

  // Byte length of an instruction given which optional fields it carries
  function automatic logic [63:0] instr_len(input logic need_regids,
                                            input logic need_valc);
    return 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_ilen_decode.sv
`default_nettype none
// ============================================================================
// Module  : ilen_decode
// Brief   : Combinational classifier: from an instruction code, tells whether
//           a register-specifier byte and/or an 8-byte constant follow, and
//           whether the code names a defined instruction at all.
// Revision: 1.0 - initial release
// ============================================================================
module ilen_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       need_regids_o,
  output logic       need_valc_o,
  output logic       instr_valid_o
);

  // Map each instruction code onto its optional-field requirements
  always_comb begin
    need_regids_o = 1'b0;
    need_valc_o   = 1'b0;
    instr_valid_o = (icode_i <= IPOPQ);
    case (icode_i)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids_o = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids_o = 1'b1;
        need_valc_o   = 1'b1;
      end
      IJXX, ICALL: need_valc_o = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Y86-64 byte-serial instruction fetch. Reads opcode, optional
//           register byte and optional 8-byte constant one byte per memory
//           handshake, presents the decoded instruction with a valid/ready
//           handshake, then waits for the next PC from the PC-update stage.
// Options : FETCH_BOUND_CHECK_EN - when defined, any byte address at or above
//           IMEM_SIZE reports an address fault without touching memory.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic [63:0] new_PC,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_err,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] PC,
  output logic [1:0]  stat
);

`ifdef FETCH_BOUND_CHECK_EN
  localparam bit c_bound_en = 1'b1;
`else
  localparam bit c_bound_en = 1'b0;
`endif

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q, ifun_d;
  logic [3:0]   ra_q, ra_d;
  logic [3:0]   rb_q, rb_d;
  logic [63:0]  valc_q, valc_d;
  logic [63:0]  valp_q, valp_d;
  logic [1:0]   stat_q, stat_d;
  logic [2:0]   cnt_q, cnt_d;

  logic [3:0]   w_dec_icode;
  logic         w_need_regids;
  logic         w_need_valc;
  logic         w_instr_valid;
  logic [63:0]  w_offset;
  logic [63:0]  w_addr;
  logic         w_fetching;
  logic         w_oob;
  logic         w_take;
  logic         w_fault;

  // While reading the opcode the decoder looks at the incoming byte; later
  // states look at the already latched icode.
  assign w_dec_icode = (state_q == F_OP) ? imem_rdata[7:4] : icode_q;

  ilen_decode u_ilen_decode (
    .icode_i       (w_dec_icode),
    .need_regids_o (w_need_regids),
    .need_valc_o   (w_need_valc),
    .instr_valid_o (w_instr_valid)
  );

  // Offset from PC of the byte the current fetch state is reading
  always_comb begin
    w_offset = 64'd0;
    case (state_q)
      F_REG:   w_offset = 64'd1;
      F_CONST: w_offset = 64'd1 + {63'd0, w_need_regids} + {61'd0, cnt_q};
      default: w_offset = 64'd0;
    endcase
  end

  // Address is modulo 2^64, so a fetch may wrap past the top of memory
  assign w_addr     = pc_q + w_offset;
  assign w_fetching = (state_q == F_OP) || (state_q == F_REG) || (state_q == F_CONST);
  assign w_oob      = c_bound_en && w_fetching && (w_addr >= 64'(IMEM_SIZE));
  // Reset gates the request directly so it drops in the same cycle
  assign imem_req   = w_fetching && !w_oob && !reset;
  assign imem_addr  = w_addr;
  assign w_take     = imem_req && imem_ack;
  assign w_fault    = w_oob || (w_take && imem_err);

  assign f_valid = (state_q == OUT);
  assign icode   = icode_q;
  assign ifun    = ifun_q;
  assign rA      = ra_q;
  assign rB      = rb_q;
  assign valC    = valc_q;
  assign valP    = valp_q;
  assign PC      = pc_q;
  assign stat    = stat_q;

  // State and datapath registers; reset discards any partial fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= F_OP;
      pc_q    <= RESET_PC;
      icode_q <= INOP;
      ifun_q  <= 4'h0;
      ra_q    <= RNONE;
      rb_q    <= RNONE;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      stat_q  <= STAT_AOK;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and field-capture logic for the fetch sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;

    case (state_q)
      F_OP: begin
        if (w_fault) begin
          stat_d  = STAT_ADR;
          state_d = OUT;
        end else if (w_take) begin
          icode_d = imem_rdata[7:4];
          ifun_d  = imem_rdata[3:0];
          cnt_d   = 3'd0;
          if (!w_instr_valid) begin
            // Undefined opcode: no more bytes are read, valP stays cleared
            stat_d  = STAT_INS;
            state_d = OUT;
          end else begin
            valp_d = pc_q + instr_len(w_need_regids, w_need_valc);
            if (imem_rdata[7:4] == IHALT) begin
              stat_d = STAT_HLT;
            end
            if (w_need_regids) begin
              state_d = F_REG;
            end else if (w_need_valc) begin
              state_d = F_CONST;
            end else begin
              state_d = OUT;
            end
          end
        end
      end

      F_REG: begin
        if (w_fault) begin
          stat_d  = STAT_ADR;
          state_d = OUT;
        end else if (w_take) begin
          ra_d    = imem_rdata[7:4];
          rb_d    = imem_rdata[3:0];
          state_d = w_need_valc ? F_CONST : OUT;
        end
      end

      F_CONST: begin
        if (w_fault) begin
          stat_d  = STAT_ADR;
          state_d = OUT;
        end else if (w_take) begin
          // Little-endian: byte k of the constant lands in valC[8k+7:8k]
          valc_d[{cnt_q, 3'b000} +: 8] = imem_rdata;
          if (cnt_q == 3'd7) begin
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      OUT: begin
        if (f_ready) begin
          state_d = (stat_q == STAT_AOK) ? WAIT_PC : HALTED;
        end
      end

      WAIT_PC: begin
        if (pc_ld) begin
          pc_d    = new_PC;
          icode_d = INOP;
          ifun_d  = 4'h0;
          ra_d    = RNONE;
          rb_d    = RNONE;
          valc_d  = 64'd0;
          valp_d  = 64'd0;
          stat_d  = STAT_AOK;
          cnt_d   = 3'd0;
          state_d = F_OP;
        end
      end

      HALTED: ;

      default: state_d = HALTED;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit: byte-addressed memory with
//           random ack latency and injectable faults, and an instruction-level
//           reference model that computes the expected decode of a PC.
// Options : FETCH_BOUND_CHECK_EN - bench then builds the DUT with IMEM_SIZE=16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [63:0] c_reset_pc = 64'h0;
`ifdef FETCH_BOUND_CHECK_EN
  localparam int c_imem = 16;
`else
  localparam int c_imem = 4096;
`endif

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [1:0]  stat;
    int          nreq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_ld = 1'b0;
  logic [63:0] new_PC = 64'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_rdata = 8'h00;
  logic        imem_err = 1'b0;
  logic        f_valid;
  logic        f_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, PC;
  logic [1:0]  stat;

  logic [7:0]  mem    [logic [63:0]];
  bit          err_at [logic [63:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acks   = 0;
  int ack_max  = 0;
  int wait_cnt = 0;
  int cur_delay = 0;

  fetch_unit #(
    .RESET_PC  (c_reset_pc),
    .IMEM_SIZE (c_imem)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_ld      (pc_ld),
    .new_PC     (new_PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .f_valid    (f_valid),
    .f_ready    (f_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .valP       (valP),
    .PC         (PC),
    .stat       (stat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic bit oob(input logic [63:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return a >= 64'(c_imem);
`else
    return (a == 64'd0) && 1'b0;
`endif
  endfunction

  // Memory: answers each request after a random 0..ack_max cycle latency
  always @(negedge clk) begin
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = 8'h00;
    if (reset) begin
      wait_cnt = 0;
    end else if (imem_req) begin
      if (wait_cnt >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = rd(imem_addr);
        imem_err   = err_at.exists(imem_addr);
        n_acks++;
        wait_cnt   = 0;
        cur_delay  = int'($urandom_range(0, ack_max));
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference: walk the instruction's bytes as an ISA-level fetch would
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    logic [7:0] b;
    logic [63:0] a;
    bit regids, needc;
    e.icode = 4'h0; e.ifun = 4'h0; e.ra = 4'hF; e.rb = 4'hF;
    e.valc = 64'd0; e.valp = 64'd0; e.stat = 2'd0; e.nreq = 0;
    if (oob(pc)) begin e.stat = 2'd2; return e; end
    e.nreq = 1;
    if (err_at.exists(pc)) begin e.stat = 2'd2; return e; end
    b = rd(pc);
    e.icode = b[7:4];
    e.ifun  = b[3:0];
    if (e.icode > 4'hB) begin e.stat = 2'd3; return e; end
    regids = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    needc  = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    e.valp = pc + 64'd1 + (regids ? 64'd1 : 64'd0) + (needc ? 64'd8 : 64'd0);
    if (e.icode == 4'h1) e.stat = 2'd1;
    a = pc + 64'd1;
    if (regids) begin
      if (oob(a)) begin e.stat = 2'd2; return e; end
      e.nreq++;
      if (err_at.exists(a)) begin e.stat = 2'd2; return e; end
      b = rd(a);
      e.ra = b[7:4];
      e.rb = b[3:0];
      a = a + 64'd1;
    end
    if (needc) begin
      for (int i = 0; i < 8; i++) begin
        if (oob(a)) begin e.stat = 2'd2; return e; end
        e.nreq++;
        if (err_at.exists(a)) begin e.stat = 2'd2; return e; end
        e.valc = e.valc | (64'(rd(a)) << (8 * i));
        a = a + 64'd1;
      end
    end
    return e;
  endfunction

  task automatic wait_valid(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (f_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic accept();
    f_ready = 1'b1;
    @(negedge clk);
    f_ready = 1'b0;
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [63:0] pc);
    check_eq({tag, "_stat"}, 64'(stat), 64'(e.stat));
    check_eq({tag, "_nreq"}, 64'(n_acks), 64'(e.nreq));
    check_eq({tag, "_pc"}, PC, pc);
    if (e.stat == 2'd0 || e.stat == 2'd1) begin
      check_eq({tag, "_op"}, {56'd0, icode, ifun}, {56'd0, e.icode, e.ifun});
      check_eq({tag, "_regs"}, {56'd0, rA, rB}, {56'd0, e.ra, e.rb});
      check_eq({tag, "_valC"}, valC, e.valc);
      check_eq({tag, "_valP"}, valP, e.valp);
    end else if (e.stat == 2'd3) begin
      check_eq({tag, "_op"}, {56'd0, icode, ifun}, {56'd0, e.icode, e.ifun});
    end
  endtask

  // Reset, then let the fixed irmovq at RESET_PC be fetched and consumed
  task automatic reset_and_sync(input bit hold);
    exp_t e;
    bit ok;
    logic [210:0] snap;
    int bad;
    @(negedge clk);
    reset = 1'b1; pc_ld = 1'b0; f_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_req_valid", {62'd0, imem_req, f_valid}, 64'd0);
    check_eq("rst_fields", {40'd0, icode, ifun, rA, rB, 6'd0, stat}, {40'd0, 4'h0, 4'h0, 4'hF, 4'hF, 8'd0});
    check_eq("rst_valC_valP", valC | valP, 64'd0);
    check_eq("rst_pc", PC, c_reset_pc);
    @(negedge clk);
    reset = 1'b0;
    n_acks = 0;
    e = model(c_reset_pc);
    wait_valid("refetch", ok);
    if (ok) begin
      compare("refetch", e, c_reset_pc);
      if (hold) begin
        snap = {icode, ifun, rA, rB, valC, valP, PC, stat, f_valid};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
          pc_ld  = (i == 2);
          new_PC = 64'h1234;
          @(negedge clk);
          if ({icode, ifun, rA, rB, valC, valP, PC, stat, f_valid} !== snap || imem_req) bad++;
        end
        pc_ld = 1'b0;
        check_eq("hold_stable", 64'(bad), 64'd0);
        check_eq("pc_ld_ignored", PC, c_reset_pc);
      end
    end
    accept();
  endtask

  // Hand the DUT a PC, check the fetched instruction, recover if it halts
  task automatic run_instr(input string tag, input logic [63:0] pc);
    exp_t e;
    bit ok;
    int bad;
    e = model(pc);
    n_acks = 0;
    pc_ld = 1'b1; new_PC = pc;
    @(negedge clk);
    pc_ld = 1'b0;
    wait_valid(tag, ok);
    if (ok) compare(tag, e, pc);
    accept();
    if (!ok || e.stat != 2'd0) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        pc_ld = (i == 1); new_PC = pc;
        @(negedge clk);
        if (imem_req || f_valid) bad++;
      end
      pc_ld = 1'b0;
      check_eq({tag, "_halted_quiet"}, 64'(bad), 64'd0);
      reset_and_sync(1'b0);
    end
  endtask

  task automatic put(input logic [63:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  initial begin
    logic [63:0] pc;
    logic [3:0]  ic;
    bit ok;
    int k;

    // Fixed instruction at RESET_PC: irmovq $10, %rbx
    put(64'd0, 8'h30); put(64'd1, 8'hF3); put(64'd2, 8'h0A);
    for (int i = 3; i < 10; i++) put(64'(i), 8'h00);

    #2 reset = 1'b1;
    ack_max = 0;
    reset_and_sync(1'b1);

    // Back-pressure already covered; now directed cases with random latency
    ack_max = 3;
    put(64'h2000, 8'h00); put(64'h2001, 8'h10);
    run_instr("nop", 64'h2000);
    run_instr("halt", 64'h2001);

    put(64'h3000, 8'hC0);
    run_instr("ins", 64'h3000);

    put(64'h4000, 8'h30); put(64'h4001, 8'hF1);
    for (int i = 2; i < 10; i++) put(64'h4000 + 64'(i), 8'(i * 17));
    err_at[64'h4002] = 1'b1;
    run_instr("adr_err", 64'h4000);
    err_at.delete();

    put(64'hFFFF_FFFF_FFFF_FFFE, 8'h60); put(64'hFFFF_FFFF_FFFF_FFFF, 8'h12);
    run_instr("wrap", 64'hFFFF_FFFF_FFFF_FFFE);

    put(64'd15, 8'h20); put(64'd16, 8'h01);
    run_instr("bound", 64'd15);

    // Reset in the middle of the constant bytes
    for (int r = 0; r < 4; r++) begin
      pc = 64'h5000 + 64'(r * 16);
      put(pc, 8'h30); put(pc + 1, 8'hF2);
      for (int i = 2; i < 10; i++) put(pc + 64'(i), 8'($urandom));
      k = int'($urandom_range(3, 6));
      n_acks = 0;
      pc_ld = 1'b1; new_PC = pc;
      @(negedge clk);
      pc_ld = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (n_acks >= k) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) check_eq("midrst_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      #1 check_eq("midrst_req_drop", {62'd0, imem_req, f_valid}, 64'd0);
      check_eq("midrst_pc", PC, c_reset_pc);
      reset_and_sync(1'b0);
    end

    // Random instructions at random PCs
    for (int t = 0; t < 40; t++) begin
      pc = {32'($urandom), 32'($urandom)};
      pc[12] = 1'b1;
      if (&pc[63:5]) pc[63] = 1'b0;
      if ($urandom_range(0, 3) == 0) ic = 4'($urandom_range(0, 15));
      else ic = 4'($urandom_range(2, 11));
      if (ic == 4'h1 && $urandom_range(0, 1) == 0) ic = 4'h6;
      put(pc, {ic, 4'($urandom)});
      for (int i = 1; i < 10; i++) put(pc + 64'(i), 8'($urandom));
      err_at.delete();
      if ($urandom_range(0, 7) == 0) err_at[pc + 64'($urandom_range(0, 9))] = 1'b1;
      run_instr("rand", pc);
    end
    err_at.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard against a wedged run
  initial begin
    #2000000;
    check_eq("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
